// File: rtl/memory_initiator_if.sv
// ---------------------------------------------------------------------------
// memory_initiator_if
//
// Purpose: request/response handshake between a requester (CPU core, loader,
// DMA engine) and the memory_initiator bus master.
//
// Signals:
//   reqValid    requester -> initiator  request present
//   reqReady    initiator -> requester  initiator can accept a request
//   reqWrite    requester -> initiator  1 = write, 0 = read
//   reqAddress  requester -> initiator  byte address
//   reqData     requester -> initiator  write data (ignored for reads)
//   respValid   initiator -> requester  one-cycle completion pulse
//   respWrite   initiator -> requester  type of the completed access
//   respData    initiator -> requester  read data, held until the next read
//
// Modports:
//   master  the requester side
//   slave   the initiator side
// ---------------------------------------------------------------------------
interface memory_initiator_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);

  logic                  reqValid;
  logic                  reqReady;
  logic                  reqWrite;
  logic [ADDR_WIDTH-1:0] reqAddress;
  logic [DATA_WIDTH-1:0] reqData;
  logic                  respValid;
  logic                  respWrite;
  logic [DATA_WIDTH-1:0] respData;

  modport master (
    output reqValid,
    output reqWrite,
    output reqAddress,
    output reqData,
    input  reqReady,
    input  respValid,
    input  respWrite,
    input  respData
  );

  modport slave (
    input  reqValid,
    input  reqWrite,
    input  reqAddress,
    input  reqData,
    output reqReady,
    output respValid,
    output respWrite,
    output respData
  );

endinterface

// File: rtl/memory_initiator.sv
// ---------------------------------------------------------------------------
// memory_initiator
//
// Purpose: bus-master front end for the shared-bus memory. A request that
// is accepted through a valid/ready handshake becomes one address/write/data
// sequence on the memory pins. The result comes back as a one-cycle
// respValid strobe. The memory's read drive and the initiator's write drive
// never overlap on dataBus.
//
// Ports:
//   clock       single clock, all state on the rising edge
//   resetN      asynchronous, active-low reset
//   req         handshake interface (slave modport): reqValid/reqReady/
//               reqWrite/reqAddress/reqData in, respValid/respWrite/respData
//               out
//   dataBus     shared memory data bus (inout, high-Z unless writing)
//   addressBus  memory address
//   write       memory write enable
//
// Parameters:
//   ADDR_WIDTH   address width (4096-byte memory by default)
//   DATA_WIDTH   data width
//   WAIT_CYCLES  cycles the bus is held after SETUP, legal range 1..15
// ---------------------------------------------------------------------------
module memory_initiator #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  resetN,
  memory_initiator_if.slave     req,
  inout  wire  [DATA_WIDTH-1:0] dataBus,
  output logic [ADDR_WIDTH-1:0] addressBus,
  output logic                  write
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_DONE
  } state_t;

  // The WAIT counter counts down to zero. A value of WAIT_CYCLES-1 therefore
  // gives exactly WAIT_CYCLES cycles in WAIT.
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  state_t                state_q,     state_d;
  logic [3:0]            wait_cnt_q,  wait_cnt_d;
  logic                  write_q,     write_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] data_q,      data_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

  logic in_access;
  logic drive_bus;

  // State register and the latched request. Reset is asynchronous. This lets
  // the write enable and the dataBus drive (both decoded from state) drop the
  // moment resetN goes low, even in the middle of an access.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Next-state logic. The request is latched at the handshake edge, so the
  // requester may change its inputs right after acceptance. Read data is
  // captured on the edge that ends the last WAIT cycle. By then the address
  // has been stable for at least one full cycle.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    data_d      = data_q;
    resp_data_d = resp_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req.reqValid) begin
          write_d = req.reqWrite;
          addr_d  = req.reqAddress;
          data_d  = req.reqData;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wait_cnt_d = WAIT_INIT;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          if (!write_q) begin
            resp_data_d = dataBus;
          end
          state_d = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus and handshake outputs decode directly from the registered state.
  // reqReady is also gated by resetN, so it stays low for as long as reset
  // is held. The initiator drives dataBus only while it is also asserting
  // write. In every other cycle the memory owns the bus.
  assign in_access  = (state_q == ST_SETUP) || (state_q == ST_WAIT);
  assign drive_bus  = in_access && write_q;
  assign write      = drive_bus;
  assign addressBus = addr_q;
  assign dataBus    = drive_bus ? data_q : {DATA_WIDTH{1'bz}};

  assign req.reqReady  = (state_q == ST_IDLE) && resetN;
  assign req.respValid = (state_q == ST_DONE);
  assign req.respWrite = (state_q == ST_DONE) && write_q;
  assign req.respData  = resp_data_q;

endmodule

// File: tb/tb_memory_initiator.sv
// ---------------------------------------------------------------------------
// tb_memory_initiator
//
// Purpose: self-checking bench for memory_initiator. It builds two
// initiators (WAIT_CYCLES = 1 and 3). Each one sits in front of its own
// behavioural shared-bus memory. Every memory starts filled with 0x88. A
// memory drives dataBus whenever write is low and stores dataBus on a rising
// edge with write high. Expected read data comes from a per-initiator
// associative-array model that is updated at request level.
// ---------------------------------------------------------------------------
module tb_memory_initiator;

  localparam int AW = 12;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic resetN;
  logic mem_init;

  always #5 clock = ~clock;

  memory_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
  memory_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

  wire  [DW-1:0] dataBus0, dataBus1;
  logic [AW-1:0] addressBus0, addressBus1;
  logic          write0, write1;

  memory_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(1)) dut0 (
    .clock(clock), .resetN(resetN), .req(if0),
    .dataBus(dataBus0), .addressBus(addressBus0), .write(write0)
  );

  memory_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(3)) dut1 (
    .clock(clock), .resetN(resetN), .req(if1),
    .dataBus(dataBus1), .addressBus(addressBus1), .write(write1)
  );

  // Shared request fields; each initiator has its own reqValid.
  logic          valid0, valid1;
  logic          reqWrite_s;
  logic [AW-1:0] reqAddress_s;
  logic [DW-1:0] reqData_s;

  assign if0.reqValid   = valid0;
  assign if0.reqWrite   = reqWrite_s;
  assign if0.reqAddress = reqAddress_s;
  assign if0.reqData    = reqData_s;
  assign if1.reqValid   = valid1;
  assign if1.reqWrite   = reqWrite_s;
  assign if1.reqAddress = reqAddress_s;
  assign if1.reqData    = reqData_s;

  // Behavioural shared-bus memories.
  logic [DW-1:0] mem0 [4096];
  logic [DW-1:0] mem1 [4096];

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) begin
        mem0[i] <= 8'h88;
        mem1[i] <= 8'h88;
      end
    end else begin
      if (write0) mem0[addressBus0] <= dataBus0;
      if (write1) mem1[addressBus1] <= dataBus1;
    end
  end

  assign dataBus0 = write0 ? {DW{1'bz}} : mem0[addressBus0];
  assign dataBus1 = write1 ? {DW{1'bz}} : mem1[addressBus1];

  // Bus monitor. While a memory is driving, the bus must carry exactly what
  // that memory is driving. Any difference means a second driver is present.
  int collisions = 0;
  always @(negedge clock) begin
    if (!mem_init && resetN !== 1'bx) begin
      if (!write0 && dataBus0 !== mem0[addressBus0]) collisions++;
      if (!write1 && dataBus1 !== mem1[addressBus1]) collisions++;
    end
  end

  // Reference memory contents, per initiator; absent entries read as 0x88.
  logic [DW-1:0] ref0 [int];
  logic [DW-1:0] ref1 [int];

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] model_read(input int sel, input int a);
    if (sel != 0) return ref1.exists(a) ? ref1[a] : 8'h88;
    return ref0.exists(a) ? ref0[a] : 8'h88;
  endfunction

  task automatic model_write(input int sel, input int a, input logic [DW-1:0] d);
    if (sel != 0) ref1[a] = d;
    else          ref0[a] = d;
  endtask

  function automatic logic obs_ready(input int sel);
    return (sel != 0) ? if1.reqReady : if0.reqReady;
  endfunction
  function automatic logic obs_valid(input int sel);
    return (sel != 0) ? if1.respValid : if0.respValid;
  endfunction
  function automatic logic obs_rwrite(input int sel);
    return (sel != 0) ? if1.respWrite : if0.respWrite;
  endfunction
  function automatic logic [DW-1:0] obs_rdata(input int sel);
    return (sel != 0) ? if1.respData : if0.respData;
  endfunction
  function automatic logic obs_write(input int sel);
    return (sel != 0) ? write1 : write0;
  endfunction
  function automatic logic [AW-1:0] obs_addr(input int sel);
    return (sel != 0) ? addressBus1 : addressBus0;
  endfunction
  function automatic logic [DW-1:0] obs_bus(input int sel);
    return (sel != 0) ? dataBus1 : dataBus0;
  endfunction

  // Runs one complete access on initiator sel. The task checks the bus
  // during the access window, the response latency (2 + WAIT_CYCLES cycles
  // after the accept edge), the response type and the read data.
  task automatic send(input int sel, input bit w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    int            g;
    int            lat;
    int            wc;
    logic          rw;
    logic [DW-1:0] rd;
    logic [DW-1:0] exp_d;
    wc  = (sel != 0) ? 3 : 1;
    lat = 0;
    rw  = 1'b0;
    rd  = '0;
    reqWrite_s   = w;
    reqAddress_s = a;
    reqData_s    = d;
    if (sel != 0) valid1 = 1'b1;
    else          valid0 = 1'b1;
    g = 0;
    while (!obs_ready(sel) && g < 50) begin
      @(posedge clock);
      #1;
      g++;
    end
    checks++;
    if (obs_ready(sel) !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_timeout dut%0d: reqReady=%b required 1", sel, obs_ready(sel));
      valid0 = 1'b0;
      valid1 = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    valid0 = 1'b0;
    valid1 = 1'b0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clock);
      if (k <= 1 + wc) begin
        checks++;
        if (obs_write(sel) !== w || obs_addr(sel) !== a) begin
          errors++;
          $display("[TB] FAIL bus_ctrl dut%0d cycle %0d: write=%b addr=%03h required write=%b addr=%03h",
                   sel, k, obs_write(sel), obs_addr(sel), w, a);
        end
        if (w) begin
          checks++;
          if (obs_bus(sel) !== d) begin
            errors++;
            $display("[TB] FAIL bus_data dut%0d cycle %0d: dataBus=%02h required %02h",
                     sel, k, obs_bus(sel), d);
          end
        end
      end
      if (obs_valid(sel) === 1'b1) begin
        lat = k;
        rw  = obs_rwrite(sel);
        rd  = obs_rdata(sel);
      end
    end
    checks++;
    if (lat != 2 + wc) begin
      errors++;
      $display("[TB] FAIL resp_latency dut%0d: %0d cycles required %0d (0 = no response)",
               sel, lat, 2 + wc);
    end
    checks++;
    if (rw !== w) begin
      errors++;
      $display("[TB] FAIL resp_write dut%0d: respWrite=%b required %b", sel, rw, w);
    end
    if (w) begin
      model_write(sel, int'(a), d);
    end else begin
      exp_d = model_read(sel, int'(a));
      checks++;
      if (rd !== exp_d) begin
        errors++;
        $display("[TB] FAIL read_data dut%0d addr %03h: respData=%02h required %02h",
                 sel, a, rd, exp_d);
      end
    end
  endtask

  task automatic test_reset();
    resetN   = 1'b0;
    mem_init = 1'b1;
    valid0   = 1'b0;
    valid1   = 1'b0;
    reqWrite_s   = 1'b0;
    reqAddress_s = '0;
    reqData_s    = '0;
    @(posedge clock);
    #1 mem_init = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (if0.reqReady !== 1'b0 || if1.reqReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: reqReady=%b/%b required 0/0", if0.reqReady, if1.reqReady);
    end
    checks++;
    if (write0 !== 1'b0 || addressBus0 !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_bus: write=%b addr=%03h required 0/000", write0, addressBus0);
    end
    checks++;
    if (if0.respValid !== 1'b0 || if0.respWrite !== 1'b0 || if0.respData !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_resp: valid=%b write=%b data=%02h required 0/0/00",
               if0.respValid, if0.respWrite, if0.respData);
    end
    resetN = 1'b1;
    @(negedge clock);
    checks++;
    if (if0.reqReady !== 1'b1 || if1.reqReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL release_ready: reqReady=%b/%b required 1/1", if0.reqReady, if1.reqReady);
    end
  endtask

  task automatic test_write_read();
    send(0, 1'b1, 12'h123, 8'h5A);
    send(0, 1'b0, 12'h123, 8'h00);
  endtask

  // The read request carries data 0x77. An initiator that wrongly drives
  // during the read would corrupt the 0x88 coming back from the memory.
  task automatic test_read_unwritten();
    send(0, 1'b0, 12'h7FF, 8'h77);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    logic [DW-1:0] datas [3];
    int            acc   [3];
    int            idx;
    int            pulses;
    bit            take;
    addrs[0] = 12'hFFE; addrs[1] = 12'hFFF; addrs[2] = 12'h000;
    datas[0] = 8'h01;   datas[1] = 8'h02;   datas[2] = 8'h03;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    idx    = 0;
    pulses = 0;
    reqWrite_s   = 1'b1;
    reqAddress_s = addrs[0];
    reqData_s    = datas[0];
    valid0       = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (if0.respValid === 1'b1) pulses++;
      take = valid0 && (if0.reqReady === 1'b1);
      if (take) acc[idx] = c;
      @(posedge clock);
      #1;
      if (take) begin
        idx++;
        if (idx < 3) begin
          reqAddress_s = addrs[idx];
          reqData_s    = datas[idx];
        end else begin
          valid0 = 1'b0;
        end
      end
    end
    valid0 = 1'b0;
    checks++;
    if (idx != 3) begin
      errors++;
      $display("[TB] FAIL stream_accepts: %0d accepted required 3", idx);
    end
    checks++;
    if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
      errors++;
      $display("[TB] FAIL stream_spacing: gaps %0d,%0d required 4,4",
               acc[1] - acc[0], acc[2] - acc[1]);
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("[TB] FAIL stream_responses: %0d respValid pulses required 3", pulses);
    end
    for (int i = 0; i < 3; i++) model_write(0, int'(addrs[i]), datas[i]);
    @(negedge clock);
    for (int i = 0; i < 3; i++) send(0, 1'b0, addrs[i], 8'hF0);
  endtask

  // Reset during the WAIT cycle of a write to 0x300. 0x300 is never read
  // again, because whether the write landed is left undefined.
  task automatic test_reset_mid_write();
    int pulses;
    pulses       = 0;
    reqWrite_s   = 1'b1;
    reqAddress_s = 12'h300;
    reqData_s    = 8'hE7;
    valid0       = 1'b1;
    for (int g = 0; g < 20 && if0.reqReady !== 1'b1; g++) begin
      @(posedge clock);
      #1;
    end
    @(posedge clock);
    #1 valid0 = 1'b0;
    @(posedge clock);
    #2;
    checks++;
    if (write0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_pre: write=%b required 1 in WAIT", write0);
    end
    resetN = 1'b0;
    #1;
    checks++;
    if (write0 !== 1'b0 || if0.reqReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_async: write=%b reqReady=%b required 0/0", write0, if0.reqReady);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (if0.respValid !== 1'b0) pulses++;
    end
    resetN = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      if (if0.respValid !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL midreset_resp: %0d respValid cycles required 0", pulses);
    end
    checks++;
    if (if0.reqReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_ready: reqReady=%b required 1", if0.reqReady);
    end
  endtask

  task automatic test_wait3();
    send(1, 1'b1, 12'h010, 8'hC3);
    send(1, 1'b0, 12'h010, 8'h3C);
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [8];
    pool[0] = 12'h000; pool[1] = 12'h001; pool[2] = 12'h0AA; pool[3] = 12'h555;
    pool[4] = 12'h7FE; pool[5] = 12'hFFF; pool[6] = 12'h800; pool[7] = 12'h123;
    for (int n = 0; n < 24; n++) begin
      send(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           pool[$urandom_range(0, 7)], 8'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_unwritten();
    test_back_to_back();
    test_reset_mid_write();
    test_wait3();
    test_random();
    @(negedge clock);
    checks++;
    if (collisions != 0) begin
      errors++;
      $display("[TB] FAIL bus_collision: %0d contended cycles required 0", collisions);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
